// File: rtl/ws2812_driver.sv
// ws2812_driver: serialises 24-bit GRB pixel colours onto a single WS2812 data
// line, one frame of NUM_PIXELS pixels at a time, with a low latch period
// between frames.
//
// Ports
//   clk          single clock (100 MHz at the default timing parameters)
//   reset        asynchronous, active-high reset
//   enable       allows a new frame to start once the latch period has elapsed
//   pixel_color  colour of pixel next_px_num: G=[7:0], R=[15:8], B=[23:16]
//   next_px_num  index of the pixel whose colour is loaded next
//   ws2812_dout  registered serial output to the LED strip
//   frame_done   one-cycle pulse when the last bit period of a frame ends
//
// State  | meaning
// LATCH  | line held low, latch counter runs up and saturates at T_LATCH-1
// SEND   | shifting out pixel bits, one T_BIT period per bit
module ws2812_driver #(
  parameter int NUM_PIXELS = 48,
  parameter int T0H        = 40,
  parameter int T1H        = 80,
  parameter int T_BIT      = 125,
  parameter int T_LATCH    = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] pixel_color,
  output logic [5:0]  next_px_num,
  output logic        ws2812_dout,
  output logic        frame_done
);

  localparam int BW = $clog2(T_BIT + 1);
  localparam int LW = $clog2(T_LATCH + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(T_BIT - 1);
  localparam logic [BW-1:0] T0H_C      = BW'(T0H);
  localparam logic [BW-1:0] T1H_C      = BW'(T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(T_LATCH - 1);
  localparam logic [5:0]    PX_LAST    = 6'(NUM_PIXELS - 1);

  typedef enum logic {LATCH, SEND} state_t;

  state_t        state;
  logic [LW-1:0] latch_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_cnt_nx;
  logic [BW-1:0] hi_lim;
  logic [4:0]    bit_idx;
  logic [23:0]   shreg;
  logic [5:0]    px_cnt;
  logic [5:0]    next_px_inc;
  logic [23:0]   load_seq;

  // Reorder the colour so the first bit on the wire sits at shreg[23]:
  // G byte first, then R, then B, each MSB first.
  assign load_seq    = {pixel_color[7:0], pixel_color[15:8], pixel_color[23:16]};
  assign bit_cnt_nx  = bit_cnt + BW'(1);
  assign hi_lim      = shreg[23] ? T1H_C : T0H_C;
  assign next_px_inc = (next_px_num == PX_LAST) ? 6'd0 : next_px_num + 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LATCH;
      latch_cnt   <= '0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      px_cnt      <= '0;
      next_px_num <= '0;
      ws2812_dout <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LATCH: begin
          ws2812_dout <= 1'b0;
          if (latch_cnt != LATCH_LAST) begin
            latch_cnt <= latch_cnt + LW'(1);
          end else if (enable) begin
            // Count 0 of every bit is high for both symbols, so the line
            // rises on the load edge itself.
            state       <= SEND;
            shreg       <= load_seq;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            px_cnt      <= '0;
            next_px_num <= next_px_inc;
            ws2812_dout <= 1'b1;
          end
        end

        SEND: begin
          if (bit_cnt == BIT_LAST) begin
            if (bit_idx == 5'd23) begin
              if (px_cnt == PX_LAST) begin
                state       <= LATCH;
                latch_cnt   <= '0;
                px_cnt      <= '0;
                frame_done  <= 1'b1;
                ws2812_dout <= 1'b0;
              end else begin
                // Back-to-back pixel load, no idle cycle in between.
                shreg       <= load_seq;
                bit_cnt     <= '0;
                bit_idx     <= '0;
                px_cnt      <= px_cnt + 6'd1;
                next_px_num <= next_px_inc;
                ws2812_dout <= 1'b1;
              end
            end else begin
              shreg       <= {shreg[22:0], 1'b0};
              bit_idx     <= bit_idx + 5'd1;
              bit_cnt     <= '0;
              ws2812_dout <= 1'b1;
            end
          end else begin
            bit_cnt     <= bit_cnt_nx;
            ws2812_dout <= (bit_cnt_nx < hi_lim);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: self-checking bench for ws2812_driver, run with shortened
// timing parameters so several whole frames fit in a short simulation.
// Expected bits are queued per frame from the colour table; a monitor decodes
// each high pulse on the line and compares it against the queue head.
module tb_ws2812_driver;

  localparam int NP         = 4;
  localparam int T0H        = 3;
  localparam int T1H        = 7;
  localparam int T_BIT      = 10;
  localparam int T_LATCH    = 40;
  localparam int FRAME_DATA = NP * 24 * T_BIT;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] pixel_color;
  logic [5:0]  next_px_num;
  logic        dout;
  logic        frame_done;

  logic [23:0] pix_tbl [64];

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];

  int hi_len   = 0;
  int lo_len   = 0;
  int prev_hi  = 0;
  bit have_prev = 1'b0;

  always #5 clk = ~clk;

  // Upstream colour source: answers with the colour of the requested pixel.
  assign pixel_color = pix_tbl[next_px_num];

  ws2812_driver #(
    .NUM_PIXELS(NP),
    .T0H       (T0H),
    .T1H       (T1H),
    .T_BIT     (T_BIT),
    .T_LATCH   (T_LATCH)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (enable),
    .pixel_color(pixel_color),
    .next_px_num(next_px_num),
    .ws2812_dout(dout),
    .frame_done (frame_done)
  );

  // Pulse decoder / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      hi_len    = 0;
      lo_len    = 0;
      have_prev = 1'b0;
    end else if (dout) begin
      if (hi_len == 0 && have_prev && lo_len < T_LATCH) begin
        vectors++;
        if (prev_hi + lo_len !== T_BIT) begin
          miscompares++;
          $display("FAIL bit_period: got %0d cycles, expected %0d", prev_hi + lo_len, T_BIT);
        end
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (hi_len != 0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bit_extra: pulse of %0d high cycles, expected no pulse", hi_len);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (hi_len !== (e ? T1H : T0H)) begin
            miscompares++;
            $display("FAIL bit_width: got %0d high cycles, expected %0d", hi_len, e ? T1H : T0H);
          end
        end
        prev_hi   = hi_len;
        have_prev = 1'b1;
        hi_len    = 0;
      end
      lo_len++;
    end
  end

  task automatic push_pixel(input logic [23:0] c);
    for (int b = 0; b < 3; b++)
      for (int i = 7; i >= 0; i--)
        exp_q.push_back(c[b*8 + i]);
  endtask

  task automatic push_frame();
    for (int p = 0; p < NP; p++) push_pixel(pix_tbl[p]);
  endtask

  task automatic wait_rise(output int n, input int budget);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dout && n < budget);
  endtask

  task automatic wait_done(output int n, input int budget);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < budget);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b0;
    for (int p = 0; p < 64; p++) pix_tbl[p] = 24'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dout !== 1'b0) begin
      miscompares++; $display("FAIL reset_dout: got %b, expected 0", dout);
    end
    vectors++;
    if (next_px_num !== 6'd0) begin
      miscompares++; $display("FAIL reset_px: got %0d, expected 0", next_px_num);
    end
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b, expected 0", frame_done);
    end
  endtask

  task automatic test_zero_frame();
    int n;
    exp_q.delete();
    push_frame();
    enable = 1'b1;
    rst    = 1'b0;
    wait_rise(n, T_LATCH + 20);
    vectors++;
    if (n !== T_LATCH) begin
      miscompares++; $display("FAIL latch_low: got %0d cycles, expected %0d", n, T_LATCH);
    end
    vectors++;
    if (next_px_num !== 6'd1) begin
      miscompares++; $display("FAIL first_load_px: got %0d, expected 1", next_px_num);
    end
    enable = 1'b0;
    wait_done(n, FRAME_DATA + 20);
    vectors++;
    if (n !== FRAME_DATA) begin
      miscompares++; $display("FAIL frame_len: got %0d cycles, expected %0d", n, FRAME_DATA);
    end
    vectors++;
    if (next_px_num !== 6'd0) begin
      miscompares++; $display("FAIL wrap_px: got %0d, expected 0", next_px_num);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++; $display("FAIL done_width: frame_done still %b, expected 0", frame_done);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL bits_left: got %0d undelivered bits, expected 0", exp_q.size());
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    repeat (3 * T_LATCH) begin
      @(negedge clk);
      if (dout !== 1'b0 || frame_done !== 1'b0 || next_px_num !== 6'd0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL idle: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_colors();
    int n;
    int steps = 0;
    int bad   = 0;
    logic [5:0] last_px;
    pix_tbl[0] = 24'h0000FF;
    pix_tbl[1] = 24'h008001;
    pix_tbl[2] = 24'hA5C33C;
    pix_tbl[3] = 24'h5A0F81;
    push_frame();
    enable = 1'b1;
    wait_rise(n, T_LATCH + 20);
    vectors++;
    if (n !== 1) begin
      miscompares++; $display("FAIL ready_start: got %0d cycles, expected 1", n);
    end
    last_px = next_px_num;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (next_px_num !== last_px) begin
        steps++;
        if (next_px_num !== 6'((last_px + 1) % NP)) bad++;
        last_px = next_px_num;
      end
    end while (!frame_done && n < FRAME_DATA + 20);
    vectors++;
    if (n !== FRAME_DATA) begin
      miscompares++; $display("FAIL color_frame_len: got %0d cycles, expected %0d", n, FRAME_DATA);
    end
    vectors++;
    if (steps !== NP - 1 || bad !== 0) begin
      miscompares++;
      $display("FAIL px_sequence: got %0d steps with %0d bad, expected %0d steps with 0 bad", steps, bad, NP - 1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    push_frame();
    wait_rise(n, T_LATCH + 20);
    vectors++;
    if (n !== T_LATCH) begin
      miscompares++; $display("FAIL relatch: got %0d cycles, expected %0d", n, T_LATCH);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (next_px_num == 6'd3) enable = 1'b0;
    end while (!frame_done && n < FRAME_DATA + 20);
    vectors++;
    if (n !== FRAME_DATA) begin
      miscompares++; $display("FAIL drop_enable_frame: got %0d cycles, expected %0d", n, FRAME_DATA);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL b2b_bits_left: got %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int p = 0; p < NP; p++) pix_tbl[p] = 24'hFFFFFF;
    push_frame();
    enable = 1'b1;
    wait_rise(n, T_LATCH + 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dout !== 1'b0) begin
      miscompares++; $display("FAIL async_dout: got %b, expected 0", dout);
    end
    vectors++;
    if (next_px_num !== 6'd0) begin
      miscompares++; $display("FAIL async_px: got %0d, expected 0", next_px_num);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) pix_tbl[p] = 24'h3C81E7 ^ 24'(p * 24'h010203);
    push_frame();
    rst = 1'b0;
    wait_rise(n, T_LATCH + 20);
    vectors++;
    if (n !== T_LATCH) begin
      miscompares++; $display("FAIL post_reset_latch: got %0d cycles, expected %0d", n, T_LATCH);
    end
    enable = 1'b0;
    wait_done(n, FRAME_DATA + 20);
    vectors++;
    if (n !== FRAME_DATA) begin
      miscompares++; $display("FAIL post_reset_frame: got %0d cycles, expected %0d", n, FRAME_DATA);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL post_reset_bits: got %0d, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_idle();
    test_colors();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
